occupancy_tracker: RTL and testbench

Downstream consumer of the pass-detection state machine's event strobes.
- Maintains a saturating room-occupancy count in binary and two-digit BCD.
- Latches a snapshot for a timed status display on request.
- Watches each pass sequence with a timeout watchdog that flags a stuck or abandoned pass.
- Outputs drive the seven-segment display driver and status LEDs.

---
 rtl/occupancy_tracker.sv | 274 +++++++++++++++++++++++++++
 tb/tb_occupancy_tracker.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_tracker.sv
// -----------------------------------------------------------------------------
// occupancy_tracker
//
// Consumes the one-cycle event strobes of the pass-detection state machine and
// maintains the room occupancy. It does four things:
//   - keeps a saturating occupancy count, in binary and as two BCD digits,
//   - latches a BCD snapshot and holds it for a timed status display,
//   - watches every pass sequence with a timeout watchdog,
//   - raises sticky error flags for over/underflow and stuck passes.
//
// Parameters
//   MAX_COUNT    saturation limit of the count (1..99)
//   SHOW_CYCLES  length of the status display hold in clock cycles (>= 1)
//   TIMEOUT      pass watchdog limit in clock cycles (>= 1)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   increment    pass-in strobe (rising edge counts)
//   decrement    pass-out strobe (rising edge counts)
//   showstat     status display request (rising edge counts)
//   seq_start    pass sequence start (rising edge arms the watchdog)
//   gradestop    high while the sensors are quiet; ends an armed pass
//   clr          synchronous clear of count, BCD digits and sticky flags
//   count        binary occupancy count
//   bcd_tens     tens digit of count
//   bcd_ones     ones digit of count
//   full         count == MAX_COUNT
//   empty        count == 0
//   ovf_err      sticky: increment requested while full
//   unf_err      sticky: decrement requested while empty
//   show_active  status display hold running
//   show_tens    latched tens digit for the display
//   show_ones    latched ones digit for the display
//   stuck        sticky: pass watchdog expired
// -----------------------------------------------------------------------------
module occupancy_tracker #(
  parameter int MAX_COUNT   = 99,
  parameter int SHOW_CYCLES = 50000000,
  parameter int TIMEOUT     = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       increment,
  input  logic       decrement,
  input  logic       showstat,
  input  logic       seq_start,
  input  logic       gradestop,
  input  logic       clr,
  output logic [6:0] count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       full,
  output logic       empty,
  output logic       ovf_err,
  output logic       unf_err,
  output logic       show_active,
  output logic [3:0] show_tens,
  output logic [3:0] show_ones,
  output logic       stuck
);

  // Timer widths sized so the load value itself fits.
  localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [6:0]        MAX_C     = 7'(MAX_COUNT);
  localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES);
  localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  typedef enum logic {
    WD_IDLE  = 1'b0,
    WD_ARMED = 1'b1
  } wd_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              inc_q, dec_q, show_q, seq_q;
  logic              inc_ev, dec_ev, show_ev, seq_ev;

  logic [6:0]        count_q, count_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [SHOW_W-1:0] show_tmr_q, show_tmr_d;
  logic [3:0]        snap_tens_q, snap_tens_d;
  logic [3:0]        snap_ones_q, snap_ones_d;

  wd_state_t         wd_state_q;
  logic [TO_W-1:0]   wd_cnt_q;
  logic              stuck_q;

  // ---------------------------------------------------------------------------
  // Rising-edge detection. The registered copies reset to 0, so an input that
  // is already high in the first cycle after reset still produces one event.
  // ---------------------------------------------------------------------------
  assign inc_ev  = increment & ~inc_q;
  assign dec_ev  = decrement & ~dec_q;
  assign show_ev = showstat  & ~show_q;
  assign seq_ev  = seq_start & ~seq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      show_q <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      inc_q  <= increment;
      dec_q  <= decrement;
      show_q <= showstat;
      seq_q  <= seq_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Count and BCD digits. The digits are counted alongside the binary value
  // (carry on 9->0, borrow on 0->9) so no divider is needed; the two always
  // move together, keeping tens*10 + ones == count.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      count_d = 7'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (inc_ev && dec_ev) begin
      // One person in and one out in the same cycle: net zero, no error.
      count_d = count_q;
    end else if (inc_ev) begin
      if (count_q < MAX_C) begin
        count_d = count_q + 7'd1;
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (dec_ev) begin
      if (count_q != 7'd0) begin
        count_d = count_q - 7'd1;
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 7'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status display hold. The snapshot is taken from the next-state digits so a
  // count change in the same cycle as the request is already included. clr
  // deliberately leaves the running display alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    show_tmr_d  = show_tmr_q;
    snap_tens_d = snap_tens_q;
    snap_ones_d = snap_ones_q;
    if (show_ev) begin
      show_tmr_d  = SHOW_LOAD;
      snap_tens_d = tens_d;
      snap_ones_d = ones_d;
    end else if (show_tmr_q != '0) begin
      show_tmr_d = show_tmr_q - SHOW_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      show_tmr_q  <= '0;
      snap_tens_q <= 4'd0;
      snap_ones_q <= 4'd0;
    end else begin
      show_tmr_q  <= show_tmr_d;
      snap_tens_q <= snap_tens_d;
      snap_ones_q <= snap_ones_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pass watchdog. Loaded with TIMEOUT on the seq_start edge; with gradestop
  // low the counter reaches zero on the TIMEOUT-th following edge, which is
  // where stuck is raised. A quiet sensor pair (gradestop) ends the pass
  // cleanly and takes precedence over a re-arm in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_state_q <= WD_IDLE;
      wd_cnt_q   <= '0;
      stuck_q    <= 1'b0;
    end else begin
      case (wd_state_q)
        WD_IDLE: begin
          if (seq_ev) begin
            wd_cnt_q   <= TO_LOAD;
            wd_state_q <= WD_ARMED;
          end
        end
        WD_ARMED: begin
          if (gradestop) begin
            wd_cnt_q   <= '0;
            wd_state_q <= WD_IDLE;
          end else if (seq_ev) begin
            wd_cnt_q <= TO_LOAD;
          end else if (wd_cnt_q <= TO_ONE) begin
            wd_cnt_q   <= '0;
            wd_state_q <= WD_IDLE;
            stuck_q    <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q - TO_ONE;
          end
        end
        default: begin
          wd_cnt_q   <= '0;
          wd_state_q <= WD_IDLE;
        end
      endcase
      // clr wins over an expiry landing in the same cycle.
      if (clr) begin
        stuck_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count       = count_q;
  assign bcd_tens    = tens_q;
  assign bcd_ones    = ones_q;
  assign full        = (count_q == MAX_C);
  assign empty       = (count_q == 7'd0);
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign show_active = (show_tmr_q != '0);
  assign show_tens   = snap_tens_q;
  assign show_ones   = snap_ones_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// Testbench for occupancy_tracker (MAX_COUNT=99, SHOW_CYCLES=4, TIMEOUT=8).
// Expected count/BCD/flag vectors are produced by a small behavioural model and
// queued when stimulus is driven, then popped and compared once the DUT has
// taken the edge. Show timer and watchdog are checked against cycle counts.
// -----------------------------------------------------------------------------
module tb_occupancy_tracker;

  logic       clk;
  logic       rst_n;
  logic       increment, decrement, showstat, seq_start, gradestop, clr;
  logic [6:0] count;
  logic [3:0] bcd_tens, bcd_ones;
  logic       full, empty, ovf_err, unf_err;
  logic       show_active;
  logic [3:0] show_tens, show_ones;
  logic       stuck;

  occupancy_tracker #(
    .MAX_COUNT  (99),
    .SHOW_CYCLES(4),
    .TIMEOUT    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .increment  (increment),
    .decrement  (decrement),
    .showstat   (showstat),
    .seq_start  (seq_start),
    .gradestop  (gradestop),
    .clr        (clr),
    .count      (count),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .full       (full),
    .empty      (empty),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err),
    .show_active(show_active),
    .show_tens  (show_tens),
    .show_ones  (show_ones),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {count, tens, ones, full, empty, ovf_err, unf_err}
  logic [18:0] act_v;
  assign act_v = {count, bcd_tens, bcd_ones, full, empty, ovf_err, unf_err};

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model
  int m_cnt = 0;
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic model_inc();
    if (m_cnt < 99) m_cnt++;
    else m_ovf = 1'b1;
  endtask

  task automatic model_dec();
    if (m_cnt > 0) m_cnt--;
    else m_unf = 1'b1;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic push_exp(input string nm);
    exp_t x;
    x.name = nm;
    x.v = {7'(m_cnt), 4'(m_cnt / 10), 4'(m_cnt % 10),
           (m_cnt == 99), (m_cnt == 0), m_ovf, m_unf};
    sb.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle-wide strobe(s), followed by one low cycle.
  task automatic pulse(input bit inc, input bit dec, input string nm);
    increment = inc;
    decrement = dec;
    if (!(inc && dec)) begin
      if (inc) model_inc();
      else if (dec) model_dec();
    end
    push_exp(nm);
    cyc();
    increment = 1'b0;
    decrement = 1'b0;
    cyc();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    increment = 0; decrement = 0; showstat = 0; seq_start = 0;
    gradestop = 1'b1; clr = 0;
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    model_clear();
    push_exp("reset_state");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    n_cmp++;
    if ({show_active, show_tens, show_ones, stuck} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_show_stuck: got %b expected %b",
               {show_active, show_tens, show_ones, stuck}, 10'd0);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_increment();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, "inc_basic");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
  endtask

  task automatic test_bcd_carry();
    // 3 -> 9, then carry to 10, then borrow back to 9
    while (m_cnt < 9) begin
      pulse(1'b1, 1'b0, "inc_to_9");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
    pulse(1'b1, 1'b0, "bcd_carry_9_10");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    pulse(1'b0, 1'b1, "bcd_borrow_10_9");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
  endtask

  task automatic test_saturate();
    while (m_cnt < 99) begin
      pulse(1'b1, 1'b0, "inc_to_99");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
    // Held level: one event only, overflow flagged after one cycle.
    increment = 1'b1;
    model_inc();
    push_exp("ovf_first_cycle");
    push_exp("ovf_held_level");
    cyc();
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    repeat (4) cyc();
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    increment = 1'b0;
    cyc();
    clr = 1'b1;
    model_clear();
    push_exp("clr_after_ovf");
    cyc();
    clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    pulse(1'b0, 1'b1, "unf_at_zero");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    clr = 1'b1;
    model_clear();
    push_exp("clr_after_unf");
    cyc();
    clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
  endtask

  task automatic test_simultaneous();
    while (m_cnt < 5) begin
      pulse(1'b1, 1'b0, "inc_to_5");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
    pulse(1'b1, 1'b1, "inc_dec_same_cycle");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
  endtask

  task automatic test_show();
    logic [9:0] act_trace;
    while (m_cnt < 42) begin
      pulse(1'b1, 1'b0, "inc_to_42");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
    showstat = 1'b1;
    cyc();
    showstat = 1'b0;
    act_trace = '0;
    for (int i = 0; i < 10; i++) begin
      act_trace[i] = show_active;
      if (i == 0) begin
        n_cmp++;
        if ({show_tens, show_ones} !== 8'h42) begin
          n_bad++;
          $display("FAIL show_snapshot: got %h expected %h", {show_tens, show_ones}, 8'h42);
        end
        increment = 1'b1;
        model_inc();
        push_exp("inc_during_show");
      end else if (i == 1) begin
        increment = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (act_v !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
        end
      end else if (i == 2) begin
        n_cmp++;
        if ({show_tens, show_ones} !== 8'h42) begin
          n_bad++;
          $display("FAIL show_snapshot_held: got %h expected %h", {show_tens, show_ones}, 8'h42);
        end
      end
      cyc();
    end
    n_cmp++;
    if (act_trace !== 10'b0000001111) begin
      n_bad++;
      $display("FAIL show_active_window: got %b expected %b", act_trace, 10'b0000001111);
    end
    // Request and count change in the same cycle: snapshot is post-update.
    showstat = 1'b1;
    increment = 1'b1;
    model_inc();
    push_exp("inc_with_show");
    cyc();
    showstat = 1'b0;
    increment = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    n_cmp++;
    if ({show_active, show_tens, show_ones} !== 9'h144) begin
      n_bad++;
      $display("FAIL show_post_update: got %h expected %h",
               {show_active, show_tens, show_ones}, 9'h144);
    end
    repeat (6) cyc();
    n_cmp++;
    if (show_active !== 1'b0) begin
      n_bad++;
      $display("FAIL show_expired: got %b expected %b", show_active, 1'b0);
    end
  endtask

  task automatic test_watchdog();
    // Expiry with gradestop held low
    gradestop = 1'b0;
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 7) begin
        n_cmp++;
        if (stuck !== 1'b0) begin
          n_bad++;
          $display("FAIL wd_before_expiry: got %b expected %b", stuck, 1'b0);
        end
      end
    end
    n_cmp++;
    if (stuck !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_expired: got %b expected %b", stuck, 1'b1);
    end
    clr = 1'b1;
    model_clear();
    push_exp("clr_after_stuck");
    cyc();
    clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_clr: got %b expected %b", stuck, 1'b0);
    end
    // Pass completes: gradestop returns high at cycle 5
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    repeat (4) cyc();
    gradestop = 1'b1;
    repeat (12) cyc();
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_completed: got %b expected %b", stuck, 1'b0);
    end
    gradestop = 1'b0;
    repeat (12) cyc();
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_idle_quiet: got %b expected %b", stuck, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      pulse(1'b1, 1'b0, "inc_before_rst");
      e = sb.pop_front();
      n_cmp++;
      if (act_v !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
      end
    end
    showstat = 1'b1;
    seq_start = 1'b1;
    gradestop = 1'b0;
    cyc();
    showstat = 1'b0;
    seq_start = 1'b0;
    repeat (2) cyc();
    // Assert reset between clock edges; outputs must clear without an edge.
    #2 rst_n = 1'b0;
    increment = 1'b1;
    #1;
    model_clear();
    push_exp("async_reset");
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    n_cmp++;
    if ({show_active, show_tens, show_ones, stuck} !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset_show_stuck: got %b expected %b",
               {show_active, show_tens, show_ones, stuck}, 10'd0);
    end
    cyc();
    rst_n = 1'b1;
    // increment already high in the first cycle after reset: one event.
    model_inc();
    push_exp("first_cycle_event");
    cyc();
    increment = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (act_v !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act_v, e.v);
    end
    repeat (12) cyc();
    n_cmp++;
    if ({stuck, show_active} !== 2'b00) begin
      n_bad++;
      $display("FAIL timers_abandoned: got %b expected %b", {stuck, show_active}, 2'b00);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_increment();
    test_bcd_carry();
    test_saturate();
    test_simultaneous();
    test_show();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
